// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bits, drives
// the oversampling edge and bit counters, and strobes the sampler,
// deserializer and parity checker. Error flags persist until the next frame.
module uart_rx_fsm #(
  parameter int Width = 8,
  parameter int PW    = 6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          RX_IN,
  input  logic [PW-1:0] Prescale,
  input  logic          Parity_en,
  input  logic          Sampled_bit,
  input  logic          Parity_err,
  output logic          Dat_samp_en,
  output logic [PW-1:0] Edge_cnt,
  output logic [3:0]    Bit_cnt,
  output logic          Deser_en,
  output logic          Par_chk_en,
  output logic          Data_valid,
  output logic          Par_err_o,
  output logic          Stop_err,
  output logic          Strt_glitch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] pre_last;    // latched Prescale-1 for the running frame
  logic          par_en_lat;  // latched Parity_en for the running frame
  logic          par_cap;     // parity checker result is valid this cycle
  logic          last_edge;

  // Map the requested oversampling rate to the final edge index; unsupported
  // rates fall back to 8x so a bad setting can never stall the counter.
  function automatic logic [PW-1:0] last_edge_of(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    case (int'(p))
      8, 16, 32: r = PW'(int'(p) - 1);
      default:   r = PW'(7);
    endcase
    return r;
  endfunction

  // Final oversample edge of the current bit.
  assign last_edge = (Edge_cnt == pre_last);

  // Frame sequencer with all outputs registered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      pre_last    <= PW'(7);
      par_en_lat  <= 1'b0;
      par_cap     <= 1'b0;
      Dat_samp_en <= 1'b0;
      Edge_cnt    <= '0;
      Bit_cnt     <= 4'd0;
      Deser_en    <= 1'b0;
      Par_chk_en  <= 1'b0;
      Data_valid  <= 1'b0;
      Par_err_o   <= 1'b0;
      Stop_err    <= 1'b0;
      Strt_glitch <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      Deser_en    <= 1'b0;
      Par_chk_en  <= 1'b0;
      Data_valid  <= 1'b0;
      Strt_glitch <= 1'b0;
      // The checker registers its result in the Par_chk_en cycle, so the
      // flag is taken one cycle after the enable pulse.
      par_cap     <= Par_chk_en;
      if (par_cap) begin
        Par_err_o <= Parity_err;
      end

      if (state != IDLE) begin
        if (last_edge) begin
          Edge_cnt <= '0;
          Bit_cnt  <= Bit_cnt + 4'd1;
        end else begin
          Edge_cnt <= Edge_cnt + PW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state       <= START;
            Edge_cnt    <= '0;
            Bit_cnt     <= 4'd0;
            Dat_samp_en <= 1'b1;
            pre_last    <= last_edge_of(Prescale);
            par_en_lat  <= Parity_en;
            Par_err_o   <= 1'b0;
            Stop_err    <= 1'b0;
          end
        end
        START: begin
          if (last_edge) begin
            if (Sampled_bit) begin
              state       <= IDLE;
              Strt_glitch <= 1'b1;
              Dat_samp_en <= 1'b0;
              Bit_cnt     <= 4'd0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_edge) begin
            Deser_en <= 1'b1;
            if (Bit_cnt == 4'(Width)) begin
              state <= par_en_lat ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (last_edge) begin
            Par_chk_en <= 1'b1;
            state      <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            Stop_err   <= ~Sampled_bit;
            Data_valid <= Sampled_bit & ~Par_err_o;
            if (!RX_IN) begin
              // Next start bit already on the line: chain straight into it.
              // The stop flag of the finished frame stays visible.
              state       <= START;
              Edge_cnt    <= '0;
              Bit_cnt     <= 4'd0;
              Dat_samp_en <= 1'b1;
              pre_last    <= last_edge_of(Prescale);
              par_en_lat  <= Parity_en;
              Par_err_o   <= 1'b0;
            end else begin
              state       <= IDLE;
              Edge_cnt    <= '0;
              Bit_cnt     <= 4'd0;
              Dat_samp_en <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          Edge_cnt    <= '0;
          Bit_cnt     <= 4'd0;
          Dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. The data sampler is modelled as a one-cycle
// delayed copy of the line, which presents each bit's value in the last
// oversample cycle of that bit as the receiver sees it.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parity_en = 1'b0;
  logic       parity_err = 1'b0;
  logic       rx_d = 1'b1;

  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en;
  logic       par_chk_en;
  logic       data_valid;
  logic       par_err_o;
  logic       stop_err;
  logic       strt_glitch;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int start_cyc = 0;
  int first_start = 0;
  int n_deser = 0, n_par = 0, n_dv = 0, n_gl = 0;
  int dv_cyc = 0, dv_prev = 0, gl_cyc = 0;
  int s_deser = 0, s_par = 0, s_dv = 0, s_gl = 0;
  logic [7:0] part_byte;

  uart_rx_fsm #(.Width(8), .PW(6)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .RX_IN      (rx_in),
    .Prescale   (prescale),
    .Parity_en  (parity_en),
    .Sampled_bit(rx_d),
    .Parity_err (parity_err),
    .Dat_samp_en(dat_samp_en),
    .Edge_cnt   (edge_cnt),
    .Bit_cnt    (bit_cnt),
    .Deser_en   (deser_en),
    .Par_chk_en (par_chk_en),
    .Data_valid (data_valid),
    .Par_err_o  (par_err_o),
    .Stop_err   (stop_err),
    .Strt_glitch(strt_glitch)
  );

  always #5 clk = ~clk;

  // Cycle counter and sampler model.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rx_d <= rx_in;
  end

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (deser_en === 1'b1) n_deser++;
    if (par_chk_en === 1'b1) n_par++;
    if (data_valid === 1'b1) begin
      dv_prev = dv_cyc;
      dv_cyc  = cyc;
      n_dv++;
    end
    if (strt_glitch === 1'b1) begin
      n_gl++;
      gl_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_deser = n_deser;
    s_par   = n_par;
    s_dv    = n_dv;
    s_gl    = n_gl;
  endtask

  // Drop the line for a start bit; after the receiver has latched the
  // settings, scramble them to show they are held for the frame.
  task automatic drive_start(input int p, input logic pe);
    prescale  = 6'(p);
    parity_en = pe;
    rx_in     = 1'b0;
    start_cyc = cyc + 1;
    @(negedge clk);
    prescale  = 6'd12;
    parity_en = ~pe;
  endtask

  task automatic drive_rest(input int p, input logic [7:0] data, input logic sendpar,
                            input logic parbit, input logic stopbit);
    repeat (p - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (p) @(negedge clk);
    end
    if (sendpar) begin
      rx_in = parbit;
      repeat (p) @(negedge clk);
    end
    rx_in = stopbit;
    repeat (p) @(negedge clk);
    rx_in = 1'b1;
  endtask

  initial begin
    // Reset behaviour, asynchronous to the clock.
    #1 rst = 1'b1;
    #1;
    chk("rst_flags", {25'd0, dat_samp_en, deser_en, par_chk_en, data_valid,
                      par_err_o, stop_err, strt_glitch}, 32'd0);
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_samp_en", 32'(dat_samp_en), 32'd0);

    // 8x, parity, 0xA5 (even parity bit 0), good stop.
    snap();
    drive_start(8, 1'b1);
    chk("a5_start_samp_en", 32'(dat_samp_en), 32'd1);
    chk("a5_start_edge", 32'(edge_cnt), 32'd0);
    chk("a5_start_bit", 32'(bit_cnt), 32'd0);
    drive_rest(8, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("a5_deser", 32'(n_deser - s_deser), 32'd8);
    chk("a5_parchk", 32'(n_par - s_par), 32'd1);
    chk("a5_dv_count", 32'(n_dv - s_dv), 32'd1);
    chk("a5_dv_latency", 32'(dv_cyc - start_cyc), 32'd88);
    chk("a5_par_err", 32'(par_err_o), 32'd0);
    chk("a5_stop_err", 32'(stop_err), 32'd0);
    chk("a5_back_idle", 32'(dat_samp_en), 32'd0);

    // 16x, no parity, 0x3C.
    snap();
    drive_start(16, 1'b0);
    drive_rest(16, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("3c_deser", 32'(n_deser - s_deser), 32'd8);
    chk("3c_parchk", 32'(n_par - s_par), 32'd0);
    chk("3c_dv_count", 32'(n_dv - s_dv), 32'd1);
    chk("3c_dv_latency", 32'(dv_cyc - start_cyc), 32'd160);

    // Start glitch: line low for two cycles only.
    snap();
    drive_start(8, 1'b0);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_count", 32'(n_gl - s_gl), 32'd1);
    chk("glitch_time", 32'(gl_cyc - start_cyc), 32'd8);
    chk("glitch_deser", 32'(n_deser - s_deser), 32'd0);
    chk("glitch_dv", 32'(n_dv - s_dv), 32'd0);
    chk("glitch_idle", 32'(dat_samp_en), 32'd0);

    // Unsupported rate 20 behaves as 8x.
    snap();
    drive_start(20, 1'b0);
    drive_rest(8, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("bad_pre_dv_count", 32'(n_dv - s_dv), 32'd1);
    chk("bad_pre_latency", 32'(dv_cyc - start_cyc), 32'd80);

    // Parity error reported by the checker.
    snap();
    parity_err = 1'b1;
    drive_start(8, 1'b1);
    drive_rest(8, 8'h0F, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    parity_err = 1'b0;
    chk("perr_flag", 32'(par_err_o), 32'd1);
    chk("perr_stop", 32'(stop_err), 32'd0);
    chk("perr_dv", 32'(n_dv - s_dv), 32'd0);
    chk("perr_parchk", 32'(n_par - s_par), 32'd1);

    // Stop bit error; parity flag clears at the new start.
    snap();
    drive_start(8, 1'b0);
    chk("perr_cleared", 32'(par_err_o), 32'd0);
    drive_rest(8, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("serr_flag", 32'(stop_err), 32'd1);
    chk("serr_dv", 32'(n_dv - s_dv), 32'd0);

    // Two back-to-back frames at 32x; stop flag clears at the first start.
    snap();
    drive_start(32, 1'b0);
    chk("serr_cleared", 32'(stop_err), 32'd0);
    first_start = start_cyc;
    drive_rest(32, 8'hC3, 1'b0, 1'b0, 1'b1);
    drive_start(32, 1'b0);
    chk("b2b_no_idle", 32'(dat_samp_en), 32'd1);
    chk("b2b_edge0", 32'(edge_cnt), 32'd0);
    chk("b2b_bit0", 32'(bit_cnt), 32'd0);
    drive_rest(32, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_dv_count", 32'(n_dv - s_dv), 32'd2);
    chk("b2b_first_dv", 32'(dv_prev - first_start), 32'd320);
    chk("b2b_spacing", 32'(dv_cyc - dv_prev), 32'd320);

    // Reset in the middle of data bit 4.
    snap();
    part_byte = 8'h96;
    drive_start(8, 1'b1);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_in = part_byte[i];
      repeat ((i == 4) ? 3 : 8) @(negedge clk);
    end
    rx_in = 1'b1;
    rst   = 1'b1;
    #1;
    chk("midrst_flags", {25'd0, dat_samp_en, deser_en, par_chk_en, data_valid,
                         par_err_o, stop_err, strt_glitch}, 32'd0);
    chk("midrst_edge", 32'(edge_cnt), 32'd0);
    chk("midrst_bit", 32'(bit_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrst_no_dv", 32'(n_dv - s_dv), 32'd0);
    chk("midrst_idle", 32'(dat_samp_en), 32'd0);

    // Clean frame after the reset.
    snap();
    drive_start(8, 1'b1);
    drive_rest(8, 8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_deser", 32'(n_deser - s_deser), 32'd8);
    chk("post_dv_count", 32'(n_dv - s_dv), 32'd1);
    chk("post_latency", 32'(dv_cyc - start_cyc), 32'd88);
    chk("post_errs", {30'd0, par_err_o, stop_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
